// File: rtl/keymap_lookup_engine.sv
// keymap_lookup_engine
// Translates a virtual key code into an OBS key value through a table of
// DEPTH entries that the host can write. Lookups run through a two-stage
// pipeline. The call side uses start/busy and the return side uses
// done/stall.
//
// Optional build macro: KEYMAP_MISS_STATS_EN
//   When defined, the block adds the miss_count and last_miss_code outputs.
//   When it is undefined, neither port nor any counter logic exists.
//
// After reset, and again after every cfg_clear, the table sweeps its valid
// bits clear, one entry per cycle (state INIT). Lookups are accepted only
// once the sweep is finished (state RUN).

module keymap_lookup_engine #(
   parameter int unsigned      CODE_W      = 32,
   parameter int unsigned      KEY_W       = 32,
   parameter int unsigned      DEPTH       = 128,
   parameter logic [KEY_W-1:0] DEFAULT_KEY = '0,
   localparam int unsigned     AW          = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   output logic              busy,
   input  logic [CODE_W-1:0] code,
   output logic              done,
   input  logic              stall,
   output logic [KEY_W-1:0]  returndata,
   input  logic              cfg_write,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [KEY_W-1:0]  cfg_writedata,
   input  logic              cfg_clear,
   output logic              ready
`ifdef KEYMAP_MISS_STATS_EN
   ,
   output logic [31:0]       miss_count,
   output logic [CODE_W-1:0] last_miss_code
`endif
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Table control state
   state_e            state_q, state_d;
   logic [AW-1:0]     sweep_q, sweep_d;

   // Table storage. It has no reset because the INIT sweep invalidates it.
   logic [KEY_W-1:0]  table_mem [DEPTH];
   logic [DEPTH-1:0]  entry_valid;

   logic              wr_en;
   logic              clr_en;

   // Read side of the table, including the same-cycle write bypass
   logic [AW-1:0]     rd_idx;
   logic              rd_bypass;
   logic [KEY_W-1:0]  rd_entry;
   logic              rd_valid;
   logic              rd_in_range;

   // Pipeline control
   logic              s2_stalled;
   logic              accept;

   // Stage 1: a lookup whose table data has already been read
   logic              s1_valid_q, s1_valid_d;
   logic              s1_in_range_q, s1_in_range_d;
   logic              s1_hit_q, s1_hit_d;
   logic [KEY_W-1:0]  s1_entry_q, s1_entry_d;
   logic              s1_miss;
   logic [KEY_W-1:0]  s1_result;

   // Stage 2: the result presented to the consumer
   logic              done_q, done_d;
   logic [KEY_W-1:0]  returndata_q, returndata_d;

`ifdef KEYMAP_MISS_STATS_EN
   logic [CODE_W-1:0] s1_code_q, s1_code_d;
   logic [31:0]       miss_count_q, miss_count_d;
   logic [CODE_W-1:0] last_miss_code_q, last_miss_code_d;
`endif

   // Next state for the INIT/RUN sequencer and its sweep counter
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      clr_en  = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            clr_en = 1'b1;
            if (cfg_clear) begin
               sweep_d = '0;
            end else if (sweep_q == AW'(DEPTH - 1)) begin
               state_d = ST_RUN;
               sweep_d = '0;
            end else begin
               sweep_d = sweep_q + AW'(1);
            end
         end
         ST_RUN: begin
            if (cfg_clear) begin
               state_d = ST_INIT;
               sweep_d = '0;
            end
         end
         default: begin
            state_d = ST_INIT;
            sweep_d = '0;
         end
      endcase
   end

   // Register for the sequencer state and the sweep counter
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_INIT;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   // Host writes land only in RUN. A clear in the same cycle drops the write.
   always_comb begin
      wr_en = cfg_write && (state_q == ST_RUN) && !cfg_clear;
   end

   // Storage for the table entry values
   always_ff @(posedge clock) begin
      if (wr_en) begin
         table_mem[cfg_addr] <= cfg_writedata;
      end
   end

   // Valid bits: INIT clears them one by one, and a write sets one
   always_ff @(posedge clock) begin
      if (clr_en) begin
         entry_valid[sweep_q] <= 1'b0;
      end else if (wr_en) begin
         entry_valid[cfg_addr] <= 1'b1;
      end
   end

   // Handshake, table read with write bypass, and next values for both stages
   always_comb begin
      s2_stalled  = done_q && stall;
      busy        = (state_q != ST_RUN) || (s1_valid_q && s2_stalled) || s2_stalled;
      ready       = (state_q == ST_RUN);
      accept      = start && !busy;

      rd_idx      = code[AW-1:0];
      rd_in_range = ((code >> AW) == '0);
      rd_bypass   = wr_en && (cfg_addr == rd_idx);
      rd_entry    = rd_bypass ? cfg_writedata : table_mem[rd_idx];
      rd_valid    = rd_bypass || entry_valid[rd_idx];

      s1_miss     = !(s1_in_range_q && s1_hit_q);
      s1_result   = s1_miss ? DEFAULT_KEY : s1_entry_q;

      s1_valid_d    = s1_valid_q;
      s1_in_range_d = s1_in_range_q;
      s1_hit_d      = s1_hit_q;
      s1_entry_d    = s1_entry_q;
      done_d        = done_q;
      returndata_d  = returndata_q;

      if (!s2_stalled) begin
         s1_valid_d = accept;
         if (accept) begin
            s1_in_range_d = rd_in_range;
            s1_hit_d      = rd_valid;
            s1_entry_d    = rd_entry;
         end
         done_d = s1_valid_q;
         if (s1_valid_q) begin
            returndata_d = s1_result;
         end
      end
   end

   // Registers for the pipeline stages. Reset discards results in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid_q    <= 1'b0;
         s1_in_range_q <= 1'b0;
         s1_hit_q      <= 1'b0;
         s1_entry_q    <= '0;
         done_q        <= 1'b0;
         returndata_q  <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_in_range_q <= s1_in_range_d;
         s1_hit_q      <= s1_hit_d;
         s1_entry_q    <= s1_entry_d;
         done_q        <= done_d;
         returndata_q  <= returndata_d;
      end
   end

   assign done       = done_q;
   assign returndata = returndata_q;

`ifdef KEYMAP_MISS_STATS_EN
   // Miss statistics: count misses entering stage 2 and remember the last missing code
   always_comb begin
      s1_code_d        = s1_code_q;
      miss_count_d     = miss_count_q;
      last_miss_code_d = last_miss_code_q;
      if (!s2_stalled && accept) begin
         s1_code_d = code;
      end
      if (!s2_stalled && s1_valid_q && s1_miss) begin
         last_miss_code_d = s1_code_q;
         if (miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_d = miss_count_q + 32'd1;
         end
      end
      if (cfg_clear) begin
         miss_count_d = '0;
      end
   end

   // Registers for the miss statistics
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_code_q        <= '0;
         miss_count_q     <= '0;
         last_miss_code_q <= '0;
      end else begin
         s1_code_q        <= s1_code_d;
         miss_count_q     <= miss_count_d;
         last_miss_code_q <= last_miss_code_d;
      end
   end

   assign miss_count     = miss_count_q;
   assign last_miss_code = last_miss_code_q;
`endif

endmodule

// File: tb/tb_keymap_lookup_engine.sv
// Testbench for keymap_lookup_engine.
// A behavioural model holds the table contents, the number of cycles left
// before the block is usable, and a queue of expected results tagged with
// the edge that accepted them. Each cycle the bench checks done, returndata,
// busy and ready against that model.
module tb_keymap_lookup_engine;

   localparam int CODE_W = 40;
   localparam int KEY_W  = 32;
   localparam int DEPTH  = 128;
   localparam int AW     = 7;

   logic              clock = 1'b0;
   logic              resetn = 1'b1;
   logic              start = 1'b0;
   logic              busy;
   logic [CODE_W-1:0] code = '0;
   logic              done;
   logic              stall = 1'b0;
   logic [KEY_W-1:0]  returndata;
   logic              cfg_write = 1'b0;
   logic [AW-1:0]     cfg_addr = '0;
   logic [KEY_W-1:0]  cfg_writedata = '0;
   logic              cfg_clear = 1'b0;
   logic              ready;
`ifdef KEYMAP_MISS_STATS_EN
   logic [31:0]       missCountOut;
   logic [CODE_W-1:0] lastMissCodeOut;
`endif

   keymap_lookup_engine #(
      .CODE_W(CODE_W), .KEY_W(KEY_W), .DEPTH(DEPTH), .DEFAULT_KEY('0)
   ) dut (
      .clock(clock), .resetn(resetn), .start(start), .busy(busy), .code(code),
      .done(done), .stall(stall), .returndata(returndata),
      .cfg_write(cfg_write), .cfg_addr(cfg_addr), .cfg_writedata(cfg_writedata),
      .cfg_clear(cfg_clear), .ready(ready)
`ifdef KEYMAP_MISS_STATS_EN
      , .miss_count(missCountOut), .last_miss_code(lastMissCodeOut)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      int               acceptEdge;
      logic [KEY_W-1:0] value;
   } result_t;

   result_t          expQ[$];
   logic [KEY_W-1:0] keyModel [DEPTH];
   bit               validModel [DEPTH];
   int               edgeCount = 0;
   int               initLeft = DEPTH;
   int               vectorCount = 0;
   int               miscompareCount = 0;

   always @(posedge clock) edgeCount <= edgeCount + 1;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [KEY_W-1:0] modelLookup(input logic [CODE_W-1:0] c);
      if (c < CODE_W'(DEPTH) && validModel[c[AW-1:0]]) return keyModel[c[AW-1:0]];
      return '0;
   endfunction

   task automatic clearModelValid();
      for (int i = 0; i < DEPTH; i++) validModel[i] = 1'b0;
   endtask

   // One clock cycle: drive inputs, check outputs against the model, update the model, then cross the edge
   task automatic applyStimulus(input bit st, input logic [CODE_W-1:0] cd, input bit stl,
                                input bit wr, input logic [AW-1:0] ad, input logic [KEY_W-1:0] wd,
                                input bit clr);
      bit      doneExp;
      bit      busyExp;
      result_t r;
      start = st; code = cd; stall = stl;
      cfg_write = wr; cfg_addr = ad; cfg_writedata = wd; cfg_clear = clr;
      #1;
      doneExp = (expQ.size() > 0) && (edgeCount >= expQ[0].acceptEdge + 1);
      busyExp = (initLeft != 0) || (doneExp && stl);
      checkOutput("done", done, doneExp);
      if (doneExp) checkOutput("returndata", returndata, expQ[0].value);
      checkOutput("busy", busy, busyExp);
      checkOutput("ready", ready, initLeft == 0);
      if (doneExp && !stl) void'(expQ.pop_front());
      if (wr && initLeft == 0 && !clr) begin
         keyModel[ad]   = wd;
         validModel[ad] = 1'b1;
      end
      if (st && !busyExp) begin
         r.acceptEdge = edgeCount + 1;
         r.value      = modelLookup(cd);
         expQ.push_back(r);
      end
      if (clr) clearModelValid();
      @(posedge clock);
      if (clr) initLeft = DEPTH;
      else if (initLeft > 0) initLeft--;
      #1;
      start = 1'b0; cfg_write = 1'b0; cfg_clear = 1'b0; stall = 1'b0;
   endtask

   task automatic idleCycles(input int n, input bit stl = 1'b0);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, stl, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic writeEntry(input logic [AW-1:0] a, input logic [KEY_W-1:0] d);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, a, d, 1'b0);
   endtask

   task automatic lookupCode(input logic [CODE_W-1:0] c);
      applyStimulus(1'b1, c, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic waitReady(input string tag);
      int n = 0;
      while (ready !== 1'b1 && n < 400) begin
         idleCycles(1);
         n++;
      end
      checkOutput(tag, n, DEPTH);
   endtask

   task automatic drain();
      int n = 0;
      while (expQ.size() > 0 && n < 50) begin
         idleCycles(1);
         n++;
      end
      checkOutput("drainEmpty", expQ.size(), 0);
   endtask

   task automatic doReset(input string tag);
      start = 1'b0; cfg_write = 1'b0; cfg_clear = 1'b0; stall = 1'b0;
      resetn = 1'b0;
      #1;
      checkOutput({tag, "Done"}, done, 0);
      checkOutput({tag, "Data"}, returndata, 0);
      checkOutput({tag, "Busy"}, busy, 1);
      checkOutput({tag, "Ready"}, ready, 0);
      expQ.delete();
      clearModelValid();
      repeat (2) @(posedge clock);
      #1;
      resetn   = 1'b1;
      initLeft = DEPTH;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [CODE_W-1:0] rc;
      logic [AW-1:0]     ra;
      bit                rw;
      for (int i = 0; i < DEPTH; i++) keyModel[i] = '0;
      clearModelValid();

      // Reset, then the initial sweep
      #1;
      doReset("reset");
      waitReady("initLen");

      // Lookup in an empty table returns DEFAULT_KEY
      lookupCode(40'd5);
      drain();

      // Single write then a lookup (latency two edges)
      writeEntry(7'h12, 32'h0000_002A);
      lookupCode(40'h12);
      idleCycles(3);

      // Back-to-back lookups, then a stall in mid-stream
      writeEntry(7'd1, 32'd11);
      writeEntry(7'd2, 32'd22);
      writeEntry(7'd3, 32'd33);
      lookupCode(40'd1);
      lookupCode(40'd2);
      lookupCode(40'd3);
      drain();
      lookupCode(40'd1);
      lookupCode(40'd2);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 40'd3, 1'b1, 1'b0, '0, '0, 1'b0);
      lookupCode(40'd3);
      drain();

      // Out-of-range codes must not alias onto entry 0x12
      lookupCode(40'h80);
      lookupCode(40'h1_0000_0012);
      drain();

      // Write bypass: a write and a lookup of address 7 in the same cycle
      applyStimulus(1'b1, 40'd7, 1'b0, 1'b1, 7'd7, 32'h99, 1'b0);
      drain();

      // Clear with a lookup in flight. The result keeps its old value.
      lookupCode(40'h12);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
      waitReady("clearInitLen");
      lookupCode(40'h12);
      drain();

      // Miss statistics after a fresh clear. A write in the same cycle as the clear is dropped.
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 7'h20, 32'h77, 1'b1);
      waitReady("clear2InitLen");
      lookupCode(40'h20);
      writeEntry(7'h12, 32'h55);
      lookupCode(40'h12);
      lookupCode(40'h80);
      lookupCode(40'h1_0000_0012);
      drain();
`ifdef KEYMAP_MISS_STATS_EN
      checkOutput("missCount", missCountOut, 3);
      checkOutput("lastMissCode", lastMissCodeOut, 40'h1_0000_0012);
`endif

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         rc = ($urandom_range(0, 9) < 8) ? CODE_W'($urandom_range(0, DEPTH - 1))
                                         : {8'($urandom), 32'($urandom)};
         rw = ($urandom_range(0, 9) < 2);
         ra = ($urandom_range(0, 1) == 0) ? rc[AW-1:0] : AW'($urandom);
         applyStimulus($urandom_range(0, 9) < 7, rc, $urandom_range(0, 9) < 3,
                       rw, ra, 32'($urandom), $urandom_range(0, 249) == 0);
      end
      drain();
      if (initLeft != 0) waitReady("randInitLen");

      // Reset with lookups in flight, then a second reset partway through the sweep
      writeEntry(7'd9, 32'h1234);
      lookupCode(40'd9);
      lookupCode(40'd1);
      doReset("midOpReset");
      idleCycles(50);
      doReset("midSweepReset");
      waitReady("resetInitLen");
      lookupCode(40'd9);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule
